// File: rtl/ioctl_dl_streamer.sv
// ioctl_dl_streamer
//   Transmit side of the ioctl download interface. Pulls bytes from a local
//   valid/ready stream and replays them as ioctl_wr strobes with incrementing
//   addresses, framed by ioctl_download, for ROM/DIP/hiscore/sample loaders.
//
// Optional feature macro: IOCTL_DL_STREAMER_CHECKSUM_EN
//   Adds the checksum output: 8-bit modulo sum of all bytes written by the
//   current transfer. It is cleared on start and is stable from done until
//   the next start.
//
// Ports
//   clk_sys, reset_n        : clock, asynchronous active-low reset
//   start, index, length    : transfer request (sampled only when idle)
//   src_valid/src_data      : byte source; src_ready accepts a byte
//   ioctl_download/index    : transfer framing and captured index
//   ioctl_wr/addr/dout      : one-cycle write strobe with address and byte
//   ioctl_wait              : consumer backpressure, honoured between writes
//   busy, done              : not-idle flag, one-cycle completion pulse
//   checksum                : (optional) sum of written bytes

module ioctl_dl_streamer #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned WR_GAP = 3,
    parameter int unsigned TAIL   = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    input  logic              ioctl_wait,
    output logic              busy,
`ifdef IOCTL_DL_STREAMER_CHECKSUM_EN
    output logic [7:0]        checksum,
`endif
    output logic              done
);

    // The FETCH cycle before each write is itself an idle cycle, so GAP only
    // needs WR_GAP-1 cycles to give WR_GAP idle cycles between strobes. GAP
    // always lasts at least one cycle so ioctl_wait is always checked there.
    localparam int unsigned GapCycles = (WR_GAP > 1) ? WR_GAP - 1 : 1;
    localparam int unsigned TmrMax    = (GapCycles > TAIL) ? GapCycles : TAIL;
    localparam int unsigned TmrW      = $clog2(TmrMax + 1);

    localparam logic [TmrW-1:0] GapLast  = TmrW'(GapCycles - 1);
    localparam logic [TmrW-1:0] TailLast = TmrW'(TAIL - 1);
    localparam logic [TmrW-1:0] TmrSat   = TmrW'(TmrMax - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StFetch,
        StWrite,
        StGap,
        StTail
    } state_e;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   tmr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dout_q;
    logic [7:0]        idx_q;
    logic              done_q;
    logic              gap_done;
    logic              accept;

    assign gap_done = (tmr_q >= GapLast);
    assign accept   = (state_q == StFetch) && src_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StSetup;
            StSetup: state_d = (len_q == '0) ? StTail : StFetch;
            StFetch: if (src_valid) state_d = StWrite;
            StWrite: state_d = StGap;
            StGap: begin
                if (gap_done && !ioctl_wait) begin
                    state_d = (cnt_q == len_q) ? StTail : StFetch;
                end
            end
            StTail:  if (tmr_q == TailLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        src_ready      = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b1;
        busy           = 1'b1;
        unique case (state_q)
            StIdle: begin
                ioctl_download = 1'b0;
                busy           = 1'b0;
            end
            StFetch: src_ready = 1'b1;
            StWrite: ioctl_wr  = 1'b1;
            default: ;
        endcase
    end

    assign ioctl_index = idx_q;
    assign ioctl_addr  = addr_q;
    assign ioctl_dout  = dout_q;
    assign done        = done_q;

    // ------------------------------------------------------------------
    // Datapath and timers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            dout_q <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            // Shared GAP/TAIL timer: restarts on every state change and
            // saturates so a long ioctl_wait cannot wrap it.
            if (state_q != state_d) begin
                tmr_q <= '0;
            end else if (tmr_q != TmrSat) begin
                tmr_q <= tmr_q + 1'b1;
            end

            if (state_q == StIdle && start) begin
                idx_q <= index;
                len_q <= length;
                cnt_q <= '0;
            end

            // Address and byte are latched together so both hold after the
            // strobe, while the counter already points at the next byte.
            if (accept) begin
                dout_q <= src_data;
                addr_q <= cnt_q;
            end

            if (state_q == StWrite) begin
                cnt_q <= cnt_q + 1'b1;
            end

            done_q <= (state_q == StTail) && (state_d == StIdle);
        end
    end

`ifdef IOCTL_DL_STREAMER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (state_q == StIdle && start) begin
            csum_q <= '0;
        end else if (state_q == StWrite) begin
            csum_q <= csum_q + dout_q;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ioctl_dl_streamer.sv
// Scoreboard bench for ioctl_dl_streamer: stimulus pushes expected writes into
// a queue, a negedge monitor pops and compares on every ioctl_wr.
module tb_ioctl_dl_streamer;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned WR_GAP = 3;
    localparam int unsigned TAIL   = 2;
    localparam int          TMO    = 3000;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        index = 8'h00;
    logic [ADDR_W-1:0] length = '0;
    logic              src_valid;
    logic [7:0]        src_data;
    logic              src_ready;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait = 1'b0;
    logic              busy;
    logic              done;
`ifdef IOCTL_DL_STREAMER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    ioctl_dl_streamer #(
        .ADDR_W (ADDR_W),
        .WR_GAP (WR_GAP),
        .TAIL   (TAIL)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .start          (start),
        .index          (index),
        .length         (length),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .busy           (busy),
`ifdef IOCTL_DL_STREAMER_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .done           (done)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // ---------------- byte source ----------------
    logic [7:0] src_mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;

    assign src_valid = !stall && (rd_ptr != wr_ptr);
    assign src_data  = src_mem[rd_ptr];

    always @(posedge clk_sys) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (src_valid && src_ready) rd_ptr <= rd_ptr + 8'd1;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]        idx;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t  exp_q[$];
    int   spacing_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_count = 0;
    int   done_count = 0;
    int   dl_cycles = 0;
    logic prev_dl = 1'b0;
    int   last_wr = -1;
    logic [7:0] model_sum = 8'h00;
    wr_t  mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_byte(input logic [7:0] idx, input int addr, input logic [7:0] data);
        wr_t e;
        e.idx  = idx;
        e.addr = ADDR_W'(addr);
        e.data = data;
        exp_q.push_back(e);
        src_mem[wr_ptr] = data;
        wr_ptr = wr_ptr + 8'd1;
        model_sum = model_sum + data;
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_dl = 1'b0;
            last_wr = -1;
        end else begin
            if (ioctl_download) dl_cycles = prev_dl ? dl_cycles + 1 : 1;
            if (ioctl_wr) begin
                wr_count++;
                if (last_wr >= 0) begin
                    spacing_q.push_back(cyc - last_wr);
                    check("wr_min_spacing", 32'((cyc - last_wr) >= int'(WR_GAP + 1)), 1);
                end
                last_wr = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(ioctl_addr), 32'(mon_e.addr));
                    check("wr_dout", 32'(ioctl_dout), 32'(mon_e.data));
                    check("wr_index", 32'(ioctl_index), 32'(mon_e.idx));
                end
            end
            if (!ioctl_download) last_wr = -1;
            if (done) begin
                done_count++;
                check("done_download_low", 32'(ioctl_download), 0);
            end
            prev_dl = ioctl_download;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_xfer(input logic [7:0] idx, input int len);
        @(posedge clk_sys); #1;
        start  = 1'b1;
        index  = idx;
        length = ADDR_W'(len);
        @(posedge clk_sys); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (done_count == prev && t < TMO) begin
            @(posedge clk_sys);
            t++;
        end
        check("done_seen", 32'(done_count > prev), 1);
        #1;
    endtask

    task automatic wait_wr(input int n);
        int t = 0;
        while (wr_count < n && t < TMO) begin
            @(posedge clk_sys);
            t++;
        end
        check("wr_seen", 32'(wr_count >= n), 1);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int p;
        int w;
        int bad;
        logic sp_ok;

        // Reset
        repeat (3) @(negedge clk_sys);
        check("reset_outputs",
              32'({ioctl_download, ioctl_wr, src_ready, busy, done, ioctl_index}), 0);
        check("reset_addr", 32'(ioctl_addr), 0);
        check("reset_dout", 32'(ioctl_dout), 0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        check("idle_busy", 32'(busy), 0);
        check("idle_download", 32'(ioctl_download), 0);

        // Basic transfer
        model_sum = 8'h00;
        push_byte(8'h00, 0, 8'hA1);
        push_byte(8'h00, 1, 8'hB2);
        push_byte(8'h00, 2, 8'hC3);
        push_byte(8'h00, 3, 8'hD4);
        spacing_q.delete();
        p = done_count;
        w = wr_count;
        start_xfer(8'h00, 4);
        wait_done(p);
        repeat (3) @(posedge clk_sys);
        check("basic_done_once", 32'(done_count), 32'(p + 1));
        check("basic_wr_count", 32'(wr_count - w), 4);
        check("basic_queue_empty", 32'(exp_q.size()), 0);
        check("basic_dl_cycles", 32'(dl_cycles), 32'(1 + 4 * (WR_GAP + 1) + TAIL));
        sp_ok = (spacing_q.size() == 3);
        foreach (spacing_q[i]) if (spacing_q[i] != int'(WR_GAP + 1)) sp_ok = 1'b0;
        check("basic_spacing", 32'(sp_ok), 1);
        check("basic_busy_after", 32'(busy), 0);
        check("basic_addr_hold", 32'(ioctl_addr), 3);
        check("basic_dout_hold", 32'(ioctl_dout), 32'h D4);
`ifdef IOCTL_DL_STREAMER_CHECKSUM_EN
        check("basic_checksum", 32'(checksum), 32'(model_sum));
`endif

        // Backpressure
        push_byte(8'h11, 0, 8'h31);
        push_byte(8'h11, 1, 8'h32);
        push_byte(8'h11, 2, 8'h33);
        spacing_q.delete();
        p = done_count;
        w = wr_count;
        start_xfer(8'h11, 3);
        wait_wr(w + 1);
        ioctl_wait = 1'b1;
        repeat (10) @(posedge clk_sys);
        #1;
        ioctl_wait = 1'b0;
        wait_done(p);
        check("bp_wr_count", 32'(wr_count - w), 3);
        check("bp_queue_empty", 32'(exp_q.size()), 0);
        check("bp_spacing_count", 32'(spacing_q.size()), 2);
        if (spacing_q.size() == 2) begin
            check("bp_held_by_wait", 32'(spacing_q[0] >= 12), 1);
            check("bp_second_spacing", 32'(spacing_q[1]), 32'(WR_GAP + 1));
        end

        // Source stall between bytes 1 and 2
        push_byte(8'h22, 0, 8'h5A);
        push_byte(8'h22, 1, 8'h6B);
        push_byte(8'h22, 2, 8'h7C);
        p = done_count;
        w = wr_count;
        start_xfer(8'h22, 3);
        wait_wr(w + 1);
        stall = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (!ioctl_download || ioctl_wr) bad++;
        end
        check("stall_no_drop_no_wr", 32'(bad), 0);
        check("stall_wr_count", 32'(wr_count - w), 1);
        @(posedge clk_sys); #1;
        stall = 1'b0;
        wait_done(p);
        check("stall_total_wr", 32'(wr_count - w), 3);
        check("stall_queue_empty", 32'(exp_q.size()), 0);

        // Zero-length transfer
        p = done_count;
        w = wr_count;
        start_xfer(8'hFE, 0);
        wait_done(p);
        repeat (3) @(posedge clk_sys);
        check("zero_dl_cycles", 32'(dl_cycles), 32'(1 + TAIL));
        check("zero_no_wr", 32'(wr_count - w), 0);
        check("zero_done_once", 32'(done_count), 32'(p + 1));
        check("zero_index", 32'(ioctl_index), 32'h FE);

        // Start while busy is ignored
        push_byte(8'h00, 0, 8'h01);
        push_byte(8'h00, 1, 8'h02);
        push_byte(8'h00, 2, 8'h03);
        push_byte(8'h00, 3, 8'h04);
        p = done_count;
        w = wr_count;
        start_xfer(8'h00, 4);
        wait_wr(w + 2);
        start_xfer(8'h02, 7);
        check("busy_start_index", 32'(ioctl_index), 32'h00);
        wait_done(p);
        repeat (4) @(posedge clk_sys);
        check("busy_start_wr_count", 32'(wr_count - w), 4);
        check("busy_start_index_end", 32'(ioctl_index), 32'h00);
        check("busy_start_idle", 32'(busy), 0);
        check("busy_start_done_once", 32'(done_count), 32'(p + 1));

        // Reset mid-transfer during GAP
        for (int i = 0; i < 8; i++) push_byte(8'h33, i, 8'(8'h80 + i));
        p = done_count;
        w = wr_count;
        start_xfer(8'h33, 8);
        wait_wr(w + 2);
        reset_n = 1'b0;
        #1;
        check("rst_mid_download", 32'(ioctl_download), 0);
        check("rst_mid_busy", 32'(busy), 0);
        exp_q.delete();
        flush = 1'b1;
        @(posedge clk_sys); #1;
        flush = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk_sys);
        check("rst_mid_no_done", 32'(done_count), 32'(p));
        check("rst_mid_wr_count", 32'(wr_count - w), 2);

        push_byte(8'h44, 0, 8'hE1);
        push_byte(8'h44, 1, 8'hF2);
        p = done_count;
        w = wr_count;
        start_xfer(8'h44, 2);
        wait_done(p);
        check("restart_wr_count", 32'(wr_count - w), 2);
        check("restart_queue_empty", 32'(exp_q.size()), 0);
        check("restart_addr_hold", 32'(ioctl_addr), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
